// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial number transmitter.
// Holds the FSM state encoding and the residue-width derivation.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } tx_state_t;

  function automatic int rw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_mod_n_step.sv
// One MSB-first step of a running mod-N residue.
// Shared with mod-N receivers so both sides compute identical residues.
module serial_mod_n_step
  import serial_tx_pkg::*;
#(
  parameter int N = 5,
  localparam int RW = rw_of(N)
) (
  input  logic [RW-1:0] acc,
  input  logic          bit_in,
  output logic [RW-1:0] acc_nxt
);

  localparam logic [RW:0] NV = (RW+1)'(N);

  logic [RW:0] t;

  // t < 2N, so a single subtraction restores the range
  always_comb begin
    t = {acc, bit_in};
    acc_nxt = (t >= NV) ? RW'(t - NV) : t[RW-1:0];
  end

endmodule

// File: rtl/serial_number_transmitter.sv
// Parallel-to-serial MSB-first transmitter with running mod-N residue.
// Reports final residue and divisibility in a one-cycle done pulse.
module serial_number_transmitter
  import serial_tx_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 5,
  localparam int RW = rw_of(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          new_bit,
  output logic          out_first,
  output logic          out_last,
  output logic          done,
  output logic [RW-1:0] residue,
  output logic          div_by_n
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  tx_state_t     state;
  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic [RW-1:0] acc;
  logic [RW-1:0] acc_nxt;
  logic          load;

  assign load = in_valid && in_ready;

  serial_mod_n_step #(
    .N(N)
  ) u_step (
    .acc    (acc),
    .bit_in (sr[W-1]),
    .acc_nxt(acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (load) begin
            state <= SHIFT;
            sr    <= in_data;
            cnt   <= CNT_TOP;
            acc   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            sr  <= sr << 1;
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state != SHIFT);
  assign out_valid = (state == SHIFT);
  assign new_bit   = out_valid && sr[W-1];
  assign out_first = out_valid && (cnt == CNT_TOP);
  assign out_last  = out_valid && (cnt == '0);
  assign done      = (state == DONE);
  assign residue   = done ? acc : '0;
  assign div_by_n  = done && (acc == '0);

endmodule
